vault_phase_lock: RTL and testbench

Parametrised successor to the single-shot switch-check phase FSM in the vault puzzle chain. It accepts a multi-digit code, one digit per `enter` strobe, and compares it against a runtime key. Failed attempts are counted; each failure below the limit triggers a timed lockout. When the retry budget is exhausted, the block enters a sticky FAIL state and raises `alarm`. It sits between the player switch/button debouncers and the vault top-level phase sequencer.

---
 rtl/vault_phase_lock.sv | 145 ++++++++++++++
 tb/tb_vault_phase_lock.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vault_phase_lock.sv
// Multi-digit code lock phase: collects DIGITS entries, compares them against a runtime key,
// enforces a timed lockout between failed attempts and a sticky alarm once retries run out.
module vault_phase_lock #(
   parameter int CODE_W         = 4,
   parameter int DIGITS         = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 16
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        start,
   input  logic                                        enter,
   input  logic [CODE_W-1:0]                           switch_in,
   input  logic [DIGITS*CODE_W-1:0]                    code_key,
   input  logic                                        clear,
   output logic                                        phase_done,
   output logic                                        phase_fail,
   output logic                                        alarm,
   output logic                                        lockout,
   output logic                                        busy,
   output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
   output logic [$clog2(MAX_TRIES+1)-1:0]              tries_left
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [TRY_W-1:0] TRY_FULL  = TRY_W'(MAX_TRIES);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_EVAL,
      S_LOCKOUT,
      S_DONE,
      S_FAIL
   } state_e;

   state_e             state_q,    state_d;
   logic [IDX_W-1:0]   idx_q,      idx_d;
   logic [TRY_W-1:0]   tries_q,    tries_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               mismatch_q, mismatch_d;

   logic [CODE_W-1:0]  key_digit;
   logic [TRY_W-1:0]   tries_dec;

   assign key_digit = code_key[idx_q*CODE_W +: CODE_W];

   // NOTE: every _d starts as its _q so paths that do not assign it hold state instead of inferring a latch.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tries_d    = tries_q;
      cnt_d      = cnt_q;
      mismatch_d = mismatch_q;
      tries_dec  = tries_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_ENTRY;
               idx_d      = '0;
               mismatch_d = 1'b0;
               tries_d    = TRY_FULL;
            end
         end

         S_ENTRY: begin
            if (enter) begin
               if (switch_in != key_digit) mismatch_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_EVAL;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         // Single decision cycle; the per-digit result never leaves the block before this point.
         S_EVAL: begin
            mismatch_d = 1'b0;
            if (!mismatch_q) begin
               state_d = S_DONE;
            end else begin
               tries_d = tries_dec;
               if (tries_dec == '0) begin
                  state_d = S_FAIL;
               end else begin
                  state_d = S_LOCKOUT;
                  cnt_d   = LOCK_LOAD;
               end
            end
         end

         S_LOCKOUT: begin
            if (cnt_q == '0) begin
               state_d = S_ENTRY;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_DONE, S_FAIL: begin
            if (clear) begin
               state_d = S_IDLE;
               tries_d = TRY_FULL;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         tries_q    <= TRY_FULL;
         cnt_q      <= '0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tries_q    <= tries_d;
         cnt_q      <= cnt_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign phase_done = (state_q == S_DONE);
   assign phase_fail = (state_q == S_FAIL);
   assign alarm      = (state_q == S_FAIL);
   assign lockout    = (state_q == S_LOCKOUT);
   assign busy       = (state_q == S_ENTRY) || (state_q == S_EVAL) || (state_q == S_LOCKOUT);
   assign digit_idx  = idx_q;
   assign tries_left = tries_q;

endmodule

// File: tb/tb_vault_phase_lock.sv
// Scoreboard bench for vault_phase_lock: default build plus a DIGITS=1 / MAX_TRIES=1 build.
module tb_vault_phase_lock;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance
   logic        reset, start, enter, clear;
   logic [3:0]  switch_in;
   logic [15:0] code_key;
   logic        phase_done, phase_fail, alarm, lockout, busy;
   logic [1:0]  digit_idx;
   logic [1:0]  tries_left;

   // degenerate instance
   logic        d_reset, d_start, d_enter, d_clear;
   logic [7:0]  d_switch, d_key;
   logic        d_done, d_fail, d_alarm, d_lockout, d_busy;
   logic [0:0]  d_idx;
   logic [0:0]  d_tries;

   vault_phase_lock u_dut (
      .clk(clk), .reset(reset), .start(start), .enter(enter), .switch_in(switch_in),
      .code_key(code_key), .clear(clear), .phase_done(phase_done), .phase_fail(phase_fail),
      .alarm(alarm), .lockout(lockout), .busy(busy), .digit_idx(digit_idx), .tries_left(tries_left)
   );

   vault_phase_lock #(.CODE_W(8), .DIGITS(1), .MAX_TRIES(1), .LOCKOUT_CYCLES(16)) u_deg (
      .clk(clk), .reset(d_reset), .start(d_start), .enter(d_enter), .switch_in(d_switch),
      .code_key(d_key), .clear(d_clear), .phase_done(d_done), .phase_fail(d_fail),
      .alarm(d_alarm), .lockout(d_lockout), .busy(d_busy), .digit_idx(d_idx), .tries_left(d_tries)
   );

   typedef enum int {OUT_DONE, OUT_LOCK, OUT_FAIL} out_e;
   typedef struct {
      out_e kind;
      int   tries;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   tries_m;

   function automatic logic [2:0] onehot(input out_e k);
      case (k)
         OUT_DONE: onehot = 3'b100;
         OUT_FAIL: onehot = 3'b010;
         default:  onehot = 3'b001;
      endcase
   endfunction

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      tries_m = 3;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   task automatic pulse_enter(input logic [3:0] d);
      @(negedge clk); switch_in = d; enter = 1'b1;
      @(negedge clk); enter = 1'b0;
   endtask

   // Enters four digits (digit 0 first), pushes the model's expected outcome, checks the EVAL cycle.
   task automatic enter_attempt(input logic [15:0] code);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (digit_idx !== 2'(i)) begin
            bad++; $display("FAIL digit_idx_step%0d: got %0d want %0d", i, digit_idx, i);
         end
         pulse_enter(code[i*4 +: 4]);
      end
      if (code == code_key) begin
         e.kind = OUT_DONE;
      end else begin
         tries_m--;
         e.kind = (tries_m == 0) ? OUT_FAIL : OUT_LOCK;
      end
      e.tries = tries_m;
      sb.push_back(e);
      total++;
      if ({phase_done, phase_fail, lockout, busy} !== 4'b0001) begin
         bad++; $display("FAIL eval_cycle: got done/fail/lock/busy=%b want 0001",
                         {phase_done, phase_fail, lockout, busy});
      end
   endtask

   task automatic wait_outcome(input string name);
      exp_t e;
      int   n = 0;
      while (!(phase_done | phase_fail | lockout) && n < 8) begin
         @(negedge clk); n++;
      end
      total++;
      if (n !== 1) begin
         bad++; $display("FAIL %s_latency: got %0d cycles want 1", name, n);
      end
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL %s_scoreboard: got empty queue want one entry", name);
      end else begin
         e = sb.pop_front();
         if ({phase_done, phase_fail, lockout} !== onehot(e.kind)) begin
            bad++; $display("FAIL %s_kind: got done/fail/lock=%b want %b", name,
                            {phase_done, phase_fail, lockout}, onehot(e.kind));
         end
         total++;
         if (tries_left !== 2'(e.tries)) begin
            bad++; $display("FAIL %s_tries: got %0d want %0d", name, tries_left, e.tries);
         end
         total++;
         if ({alarm, busy} !== {e.kind == OUT_FAIL, e.kind == OUT_LOCK}) begin
            bad++; $display("FAIL %s_alarm_busy: got %b want %b", name, {alarm, busy},
                            {e.kind == OUT_FAIL, e.kind == OUT_LOCK});
         end
      end
   endtask

   // Counts lockout cycles while pulsing enter each cycle; those pulses must be ignored.
   task automatic wait_lockout(input string name);
      int cnt = 0;
      while (lockout && cnt < 40) begin
         cnt++;
         total++;
         if (digit_idx !== 2'd0) begin
            bad++; $display("FAIL %s_lock_idx: got %0d want 0", name, digit_idx);
         end
         switch_in = 4'h3; enter = 1'b1;
         @(negedge clk);
      end
      enter = 1'b0;
      total++;
      if (cnt !== 16) begin
         bad++; $display("FAIL %s_lock_len: got %0d want 16", name, cnt);
      end
      total++;
      if ({busy, lockout, digit_idx} !== 4'b1000) begin
         bad++; $display("FAIL %s_after_lock: got busy/lock/idx=%b want 1000", name,
                         {busy, lockout, digit_idx});
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({phase_done, phase_fail, alarm, lockout, busy, digit_idx, tries_left} !== 9'b00000_00_11) begin
         bad++; $display("FAIL reset_values: got %b want 000000011",
                         {phase_done, phase_fail, alarm, lockout, busy, digit_idx, tries_left});
      end
      reset = 1'b0; d_reset = 1'b0;
      // enter/clear in IDLE are ignored
      pulse_enter(4'h3);
      pulse_clear();
      total++;
      if ({busy, digit_idx, phase_done} !== 4'b0000) begin
         bad++; $display("FAIL idle_ignore: got busy/idx/done=%b want 0000", {busy, digit_idx, phase_done});
      end
   endtask

   task automatic test_correct();
      pulse_start();
      enter_attempt(16'hD1A3);
      wait_outcome("correct");
   endtask

   task automatic test_wrong_then_right();
      pulse_clear();
      total++;
      if ({phase_done, busy, tries_left} !== 4'b0011) begin
         bad++; $display("FAIL clear_done: got done/busy/tries=%b want 0011", {phase_done, busy, tries_left});
      end
      pulse_start();
      enter_attempt(16'hC1A3);
      wait_outcome("wrong1");
      wait_lockout("wrong1");
      enter_attempt(16'hD1A3);
      wait_outcome("retry_ok");
   endtask

   task automatic test_three_wrong();
      pulse_clear();
      pulse_start();
      enter_attempt(16'hC1A3); wait_outcome("fail_a"); wait_lockout("fail_a");
      enter_attempt(16'hC1A3); wait_outcome("fail_b"); wait_lockout("fail_b");
      enter_attempt(16'hC1A3); wait_outcome("fail_c");
      pulse_enter(4'h3);
      pulse_start();
      total++;
      if ({phase_fail, alarm, lockout, busy, tries_left} !== 6'b110000) begin
         bad++; $display("FAIL fail_sticky: got %b want 110000", {phase_fail, alarm, lockout, busy, tries_left});
      end
      pulse_clear();
      total++;
      if ({phase_fail, alarm, busy, tries_left} !== 5'b00011) begin
         bad++; $display("FAIL clear_fail: got %b want 00011", {phase_fail, alarm, busy, tries_left});
      end
   endtask

   task automatic test_first_digit_wrong();
      pulse_start();
      enter_attempt(16'hD1A0);
      wait_outcome("first_wrong");
      wait_lockout("first_wrong");
   endtask

   task automatic test_async_reset();
      pulse_enter(4'h3);
      pulse_enter(4'hA);
      total++;
      if (digit_idx !== 2'd2) begin
         bad++; $display("FAIL mid_entry_idx: got %0d want 2", digit_idx);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({phase_done, phase_fail, alarm, lockout, busy, digit_idx, tries_left} !== 9'b00000_00_11) begin
         bad++; $display("FAIL async_reset: got %b want 000000011",
                         {phase_done, phase_fail, alarm, lockout, busy, digit_idx, tries_left});
      end
      @(negedge clk); reset = 1'b0;
      pulse_start();
      enter_attempt(16'hD1A3);
      wait_outcome("post_reset");
   endtask

   task automatic d_attempt(input logic [7:0] d, input string name);
      exp_t e;
      @(negedge clk); d_start = 1'b1;
      @(negedge clk); d_start = 1'b0; d_switch = d; d_enter = 1'b1;
      @(negedge clk); d_enter = 1'b0;
      e.kind  = (d == d_key) ? OUT_DONE : OUT_FAIL;
      e.tries = (d == d_key) ? 1 : 0;
      sb.push_back(e);
      total++;
      if ({d_busy, d_done, d_fail, d_lockout, d_idx} !== 5'b10000) begin
         bad++; $display("FAIL %s_eval: got busy/done/fail/lock/idx=%b want 10000", name,
                         {d_busy, d_done, d_fail, d_lockout, d_idx});
      end
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({d_done, d_fail, d_lockout} !== onehot(e.kind)) begin
         bad++; $display("FAIL %s_kind: got done/fail/lock=%b want %b", name,
                         {d_done, d_fail, d_lockout}, onehot(e.kind));
      end
      total++;
      if ({d_alarm, d_busy, d_tries} !== {e.kind == OUT_FAIL, 1'b0, 1'(e.tries)}) begin
         bad++; $display("FAIL %s_alarm_tries: got %b want %b", name, {d_alarm, d_busy, d_tries},
                         {e.kind == OUT_FAIL, 1'b0, 1'(e.tries)});
      end
   endtask

   task automatic test_degenerate();
      d_attempt(8'h5C, "deg_ok");
      #2 d_reset = 1'b1;
      @(negedge clk); d_reset = 1'b0;
      d_attempt(8'h5D, "deg_bad");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; enter = 1'b0; clear = 1'b0;
      switch_in = '0; code_key = 16'hD1A3;
      d_reset = 1'b1; d_start = 1'b0; d_enter = 1'b0; d_clear = 1'b0;
      d_switch = '0; d_key = 8'h5C;
      tries_m = 3;
      test_reset();
      test_correct();
      test_wrong_then_right();
      test_three_wrong();
      test_first_digit_wrong();
      test_async_reset();
      test_degenerate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
